// File: rtl/decode_pkg.sv
// Shared types for the ARM decode stage: instruction classes, handshake states,
// the decoded-instruction record and the immediate rotate helper.
package decode_pkg;

    localparam int INSTR_W   = 32;
    localparam int REG_IDX_W = 4;

    typedef enum logic [1:0] {
        CLS_DP     = 2'd0,
        CLS_LDST   = 2'd1,
        CLS_BRANCH = 2'd2,
        CLS_UNDEF  = 2'd3
    } inst_class_e;

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        WAITLO = 2'd1,
        WAITHI = 2'd2,
        HOLD   = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0]           cond;
        inst_class_e          instClass;
        logic [3:0]           opcode;
        logic                 sBit;
        logic [REG_IDX_W-1:0] rn;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rm;
        logic                 useImm;
        logic [INSTR_W-1:0]   imm;
        logic [1:0]           shiftType;
        logic [4:0]           shiftAmt;
    } decoded_t;

    function automatic logic [31:0] ror32(input logic [31:0] value, input logic [4:0] amount);
        logic [63:0] doubled;
        doubled = {value, value} >> amount;
        return doubled[31:0];
    endfunction

endpackage

// File: rtl/decode_stage_fields.sv
// Purely combinational ARM field splitter: one 32-bit word in, one decoded record out.
module decode_fields
    import decode_pkg::*;
(
    input  logic [INSTR_W-1:0] word_i,
    output decoded_t           fields_o
);

    always_comb begin
        fields_o           = '0;
        fields_o.cond      = word_i[31:28];
        fields_o.rn        = word_i[19:16];
        fields_o.rd        = word_i[15:12];
        fields_o.rm        = word_i[3:0];
        fields_o.shiftType = word_i[6:5];
        fields_o.shiftAmt  = word_i[11:7];
        fields_o.instClass = CLS_UNDEF;

        if (word_i[27:26] == 2'b00) begin
            fields_o.instClass = CLS_DP;
            fields_o.opcode    = word_i[24:21];
            fields_o.sBit      = word_i[20];
            // Rotate field counts in pairs of bits, so the amount is always even.
            if (word_i[25]) begin
                fields_o.useImm = 1'b1;
                fields_o.imm    = ror32({24'b0, word_i[7:0]}, {word_i[11:8], 1'b0});
            end
        end else if (word_i[27:26] == 2'b01) begin
            fields_o.instClass = CLS_LDST;
            fields_o.opcode    = {word_i[24], word_i[23], word_i[22], word_i[20]};
            if (!word_i[25]) begin
                fields_o.useImm = 1'b1;
                fields_o.imm    = {20'b0, word_i[11:0]};
            end
        end else if (word_i[27:25] == 3'b101) begin
            fields_o.instClass = CLS_BRANCH;
            fields_o.opcode    = {3'b000, word_i[24]};
            fields_o.useImm    = 1'b1;
            fields_o.imm       = {{8{word_i[23]}}, word_i[23:0]};
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: toggle/level handshake to fetch, one-entry prefetch, valid/ready to execute.
// Optional DECODE_READY_SYNC_EN adds a 2-flop synchronizer on readyIn.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int REG_W  = REG_IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              triggerOut,
    input  logic              readyIn,
    input  logic [DATA_W-1:0] dataIn,
    output logic              decValid,
    input  logic              execReady,
    input  logic              flush,
    output logic [3:0]        cond,
    output logic [1:0]        instClass,
    output logic [3:0]        opcode,
    output logic              sBit,
    output logic [REG_W-1:0]  rn,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rm,
    output logic              useImm,
    output logic [DATA_W-1:0] imm,
    output logic [1:0]        shiftType,
    output logic [4:0]        shiftAmt
);

    state_e             stateQ;
    logic               trigQ;
    logic               discardQ;
    logic               wordFullQ;
    logic [DATA_W-1:0]  wordQ;
    logic               decValidQ;
    decoded_t           outQ;
    decoded_t           decoded;
    logic               readyUse;
    logic               drain;
    logic               space;
    logic               captureNow;
    logic               keepWord;

`ifdef DECODE_READY_SYNC_EN
    logic [1:0] readySyncQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readySyncQ <= 2'b00;
        end else begin
            readySyncQ <= {readySyncQ[0], readyIn};
        end
    end

    assign readyUse = readySyncQ[1];
`else
    assign readyUse = readyIn;
`endif

    decode_fields u_fields (
        .word_i   (wordQ),
        .fields_o (decoded)
    );

    // wordQ doubles as capture register and prefetch buffer; it drains whenever the output slot frees.
    assign drain      = wordFullQ && (!decValidQ || execReady) && !flush;
    assign space      = !wordFullQ || drain || flush;
    assign captureNow = (stateQ == WAITHI) && readyUse;
    assign keepWord   = captureNow && !discardQ && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= REQ;
            trigQ     <= 1'b0;
            discardQ  <= 1'b0;
            wordFullQ <= 1'b0;
            wordQ     <= '0;
        end else begin
            case (stateQ)
                REQ: begin
                    trigQ  <= ~trigQ;
                    stateQ <= WAITLO;
                end
                WAITLO: begin
                    if (!readyUse) begin
                        stateQ <= WAITHI;
                    end
                end
                WAITHI: begin
                    if (readyUse) begin
                        stateQ <= keepWord ? HOLD : REQ;
                    end
                end
                HOLD: begin
                    if (space) begin
                        trigQ  <= ~trigQ;
                        stateQ <= WAITLO;
                    end
                end
                default: stateQ <= REQ;
            endcase

            if (keepWord) begin
                wordQ     <= dataIn;
                wordFullQ <= 1'b1;
            end else if (flush || drain) begin
                wordFullQ <= 1'b0;
            end

            // An in-flight request hit by a flush must still finish its handshake before it is dropped.
            if (captureNow) begin
                discardQ <= 1'b0;
            end else if (flush && (stateQ == WAITLO || stateQ == WAITHI)) begin
                discardQ <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            decValidQ <= 1'b0;
            outQ      <= '0;
        end else if (flush) begin
            decValidQ <= 1'b0;
        end else if (drain) begin
            decValidQ <= 1'b1;
            outQ      <= decoded;
        end else if (execReady) begin
            decValidQ <= 1'b0;
        end
    end

    assign triggerOut = trigQ;
    assign decValid   = decValidQ;
    assign cond       = outQ.cond;
    assign instClass  = outQ.instClass;
    assign opcode     = outQ.opcode;
    assign sBit       = outQ.sBit;
    assign rn         = outQ.rn;
    assign rd         = outQ.rd;
    assign rm         = outQ.rm;
    assign useImm     = outQ.useImm;
    assign imm        = outQ.imm;
    assign shiftType  = outQ.shiftType;
    assign shiftAmt   = outQ.shiftAmt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a behavioural toggle/ready fetch model.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        triggerOut;
    logic        readyIn = 1'b1;
    logic [31:0] dataIn = '0;
    logic        decValid;
    logic        execReady;
    logic        flush;
    logic [3:0]  cond;
    logic [1:0]  instClass;
    logic [3:0]  opcode;
    logic        sBit;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic        useImm;
    logic [31:0] imm;
    logic [1:0]  shiftType;
    logic [4:0]  shiftAmt;

    int vectors;
    int miscompares;

    logic [31:0] words [0:15];
    int          wordIdx = 0;
    int          fetchDelay = 5;
    int          toggleCount = 0;
    int          countdown = 0;
    logic        lastTrig = 1'b0;
    logic        pending = 1'b0;

    decode_stage dut (
        .clk        (clk),
        .reset      (reset),
        .triggerOut (triggerOut),
        .readyIn    (readyIn),
        .dataIn     (dataIn),
        .decValid   (decValid),
        .execReady  (execReady),
        .flush      (flush),
        .cond       (cond),
        .instClass  (instClass),
        .opcode     (opcode),
        .sBit       (sBit),
        .rn         (rn),
        .rd         (rd),
        .rm         (rm),
        .useImm     (useImm),
        .imm        (imm),
        .shiftType  (shiftType),
        .shiftAmt   (shiftAmt)
    );

    always #5 clk = ~clk;

    // Fetch reacts shortly after each rising edge: a toggle drops ready, data follows fetchDelay cycles later.
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            lastTrig = 1'b0;
            pending  = 1'b0;
            readyIn  = 1'b1;
        end else if (triggerOut !== lastTrig) begin
            lastTrig    = triggerOut;
            toggleCount = toggleCount + 1;
            pending     = 1'b1;
            countdown   = fetchDelay;
            readyIn     = 1'b0;
        end else if (pending) begin
            countdown = countdown - 1;
            if (countdown == 0) begin
                dataIn  = words[wordIdx];
                wordIdx = wordIdx + 1;
                readyIn = 1'b1;
                pending = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic execV, input logic flushV);
        #1;
        reset     = rstV;
        execReady = execV;
        flush     = flushV;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitValid(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (decValid !== 1'b1 && n < maxCycles) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput(tag, 32'(decValid), 32'd1);
    endtask

    task automatic checkDecode(input string tag, input logic [3:0] condE, input inst_class_e clsE,
                               input logic [3:0] opcE, input logic [3:0] rnE, input logic [3:0] rdE,
                               input logic useImmE, input logic [31:0] immE);
        checkOutput({tag, "_valid"}, 32'(decValid), 32'd1);
        checkOutput({tag, "_cond"}, 32'(cond), 32'(condE));
        checkOutput({tag, "_class"}, 32'(instClass), 32'(clsE));
        checkOutput({tag, "_opcode"}, 32'(opcode), 32'(opcE));
        checkOutput({tag, "_rn"}, 32'(rn), 32'(rnE));
        checkOutput({tag, "_rd"}, 32'(rd), 32'(rdE));
        checkOutput({tag, "_useImm"}, 32'(useImm), 32'(useImmE));
        checkOutput({tag, "_imm"}, imm, immE);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        execReady   = 1'b0;
        flush       = 1'b0;
        foreach (words[i]) words[i] = 32'h0;
        words[0] = 32'hE3A0_10FF;
        words[1] = 32'hE3A0_14FF;
        words[2] = 32'hEAFF_FFFE;
        words[3] = 32'hE591_2004;
        words[4] = 32'h1111_1111;
        words[5] = 32'h2222_2222;
        words[6] = 32'hE081_21C3;
        words[7] = 32'hEC00_0000;
        words[8] = 32'h3333_3333;
        words[9] = 32'hE280_0F01;

        waitCycles(3);
        checkOutput("rst_trigger", 32'(triggerOut), 32'd0);
        checkOutput("rst_valid", 32'(decValid), 32'd0);
        checkOutput("rst_imm", imm, 32'd0);
        checkOutput("rst_opcode", 32'(opcode), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("first_toggle_count", 32'(toggleCount), 32'd1);
        checkOutput("first_toggle_level", 32'(triggerOut), 32'd1);
        waitValid("first_word_timeout", 30);
        checkDecode("mov_imm", 4'hE, CLS_DP, 4'hD, 4'h0, 4'h1, 1'b1, 32'h0000_00FF);
        checkOutput("mov_imm_rm", 32'(rm), 32'hF);
        checkOutput("prefetch_toggle", 32'(toggleCount), 32'd2);

        waitCycles(20);
        checkOutput("stall_toggles", 32'(toggleCount), 32'd2);
        checkOutput("stall_valid", 32'(decValid), 32'd1);
        checkOutput("stall_hold_imm", imm, 32'h0000_00FF);

        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCycles(1);
        checkDecode("rot_imm", 4'hE, CLS_DP, 4'hD, 4'h0, 4'h1, 1'b1, 32'hFF00_0000);
        checkOutput("rot_toggle", 32'(toggleCount), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0);

        waitCycles(10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCycles(1);
        checkDecode("branch", 4'hE, CLS_BRANCH, 4'h0, 4'hF, 4'hF, 1'b1, 32'hFFFF_FFFE);
        checkOutput("branch_toggle", 32'(toggleCount), 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b0);

        waitCycles(10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCycles(1);
        checkDecode("ldr", 4'hE, CLS_LDST, 4'hD, 4'h1, 4'h2, 1'b1, 32'h0000_0004);
        checkOutput("ldr_toggle", 32'(toggleCount), 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b0);

        waitCycles(10);
        fetchDelay = 8;
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("flush_hold_valid", 32'(decValid), 32'd0);
        checkOutput("flush_hold_toggle", 32'(toggleCount), 32'd6);
        applyStimulus(1'b1, 1'b0, 1'b0);

        waitCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("flush_waithi_valid", 32'(decValid), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitValid("post_flush_timeout", 40);
        checkDecode("add_reg", 4'hE, CLS_DP, 4'h4, 4'h1, 4'h2, 1'b0, 32'h0000_0000);
        checkOutput("add_reg_rm", 32'(rm), 32'h3);
        checkOutput("add_reg_shiftType", 32'(shiftType), 32'd2);
        checkOutput("add_reg_shiftAmt", 32'(shiftAmt), 32'd3);
        checkOutput("add_reg_sBit", 32'(sBit), 32'd0);
        checkOutput("post_flush_toggles", 32'(toggleCount), 32'd8);

        waitCycles(14);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCycles(1);
        checkDecode("undef", 4'hE, CLS_UNDEF, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0000_0000);
        checkOutput("undef_toggle", 32'(toggleCount), 32'd9);
        applyStimulus(1'b1, 1'b0, 1'b0);

        waitCycles(14);
        checkOutput("pre_reset_trigger", 32'(triggerOut), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("async_reset_valid", 32'(decValid), 32'd0);
        checkOutput("async_reset_trigger", 32'(triggerOut), 32'd0);
        waitCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("rerun_toggle_count", 32'(toggleCount), 32'd10);
        checkOutput("rerun_toggle_level", 32'(triggerOut), 32'd1);
        waitValid("rerun_word_timeout", 40);
        checkDecode("add_rot_wrap", 4'hE, CLS_DP, 4'h4, 4'h0, 4'h0, 1'b1, 32'h0000_0004);
        checkOutput("rerun_prefetch_toggle", 32'(toggleCount), 32'd11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
